// File: rtl/btn_pkg.sv
// Shared definitions for the button conditioning slice: default timing,
// counter sizing helper and the button index used by the control block.
package btn_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 50000;
  localparam int unsigned TICK_DIV_DEF        = 50000000;

  typedef enum logic [1:0] {
    BTN_RESTART = 2'd0,
    BTN_PAUSE   = 2'd1
  } btn_idx_t;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int unsigned cntWidth(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button input path: polarity normalise, 2-FF synchroniser, debounce
// counter, accepted stable level and single-cycle press indication.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic iClk,
  input  logic iRst_n,
  input  logic iBtn,
  output logic oStable,
  output logic oPress
);

  localparam int unsigned     CW       = cntWidth(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          btnNorm;
  logic          sync1;
  logic          sync2;
  logic          stable;
  logic          stableD;
  logic [CW-1:0] cnt;

  assign btnNorm = BTN_ACTIVE_LOW ? ~iBtn : iBtn;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btnNorm;
      sync2 <= sync1;
    end
  end

  // Any return to the accepted level wipes the count: no partial credit.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (sync2 == stable) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt    <= '0;
      stable <= sync2;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      stableD <= 1'b0;
    end else begin
      stableD <= stable;
    end
  end

  assign oStable = stable;
  assign oPress  = stable & ~stableD;

endmodule

// File: rtl/btn_ctrl_cond.sv
// Conditions the restart/pause buttons into clean FSM controls and produces
// the slow step tick that is frozen while paused or restarting.
module btn_ctrl_cond
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned TICK_DIV        = TICK_DIV_DEF,
  parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic iClk,
  input  logic iRst_n,
  input  logic iBtnRestart,
  input  logic iBtnPause,
  output logic oRestart,
  output logic oPause,
  output logic oRestartPulse,
  output logic oTick
);

  localparam int unsigned   TW        = cntWidth(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [1:0]    btnRaw;
  logic [1:0]    btnStable;
  logic [1:0]    btnPress;
  logic          unusedPauseLevel;

  logic          restartQ;
  logic          pauseQ;
  logic          pulseQ;
  logic          tickQ;
  logic [TW-1:0] tickCnt;
  logic          pauseNext;
  logic          holdNext;

  assign btnRaw[int'(BTN_RESTART)] = iBtnRestart;
  assign btnRaw[int'(BTN_PAUSE)]   = iBtnPause;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
  ) uRestartDb (
    .iClk    (iClk),
    .iRst_n  (iRst_n),
    .iBtn    (btnRaw[int'(BTN_RESTART)]),
    .oStable (btnStable[int'(BTN_RESTART)]),
    .oPress  (btnPress[int'(BTN_RESTART)])
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
  ) uPauseDb (
    .iClk    (iClk),
    .iRst_n  (iRst_n),
    .iBtn    (btnRaw[int'(BTN_PAUSE)]),
    .oStable (btnStable[int'(BTN_PAUSE)]),
    .oPress  (btnPress[int'(BTN_PAUSE)])
  );

  // Pause acts on presses only; its held level has no consumer.
  assign unusedPauseLevel = btnStable[int'(BTN_PAUSE)];

  always_comb begin
    pauseNext = pauseQ;
    if (btnPress[int'(BTN_RESTART)]) begin
      pauseNext = 1'b0;
    end else if (btnPress[int'(BTN_PAUSE)] && !btnStable[int'(BTN_RESTART)]) begin
      pauseNext = ~pauseQ;
    end
    holdNext = pauseNext | btnStable[int'(BTN_RESTART)];
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      restartQ <= 1'b0;
      pulseQ   <= 1'b0;
      pauseQ   <= 1'b0;
    end else begin
      restartQ <= btnStable[int'(BTN_RESTART)];
      pulseQ   <= btnPress[int'(BTN_RESTART)];
      pauseQ   <= pauseNext;
    end
  end

  // Counter is held by the registered controls so counting restarts from 0
  // the cycle they drop; the strobe is gated by their next values so no tick
  // escapes on the edge where a hold begins.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      tickCnt <= '0;
      tickQ   <= 1'b0;
    end else begin
      if (pauseQ || restartQ || (tickCnt == TICK_LAST)) begin
        tickCnt <= '0;
      end else begin
        tickCnt <= tickCnt + 1'b1;
      end
      tickQ <= !holdNext && !pauseQ && !restartQ && (tickCnt == TICK_LAST);
    end
  end

  assign oRestart      = restartQ;
  assign oPause        = pauseQ;
  assign oRestartPulse = pulseQ;
  assign oTick         = tickQ;

endmodule

// File: tb/tb_btn_ctrl_cond.sv
// Scenario bench for btn_ctrl_cond with DEBOUNCE_CYCLES=4, TICK_DIV=5,
// active-low buttons; expected {oRestart,oPause,oRestartPulse,oTick} per cycle.
module tb_btn_ctrl_cond;

  logic iClk;
  logic iRst_n;
  logic iBtnRestart;
  logic iBtnPause;
  logic oRestart;
  logic oPause;
  logic oRestartPulse;
  logic oTick;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [3:0]  expQ[$];
  logic [3:0]  expV;
  logic [3:0]  obs;

  assign obs = {oRestart, oPause, oRestartPulse, oTick};

  btn_ctrl_cond #(
    .DEBOUNCE_CYCLES (4),
    .TICK_DIV        (5),
    .BTN_ACTIVE_LOW  (1'b1)
  ) dut (
    .iClk          (iClk),
    .iRst_n        (iRst_n),
    .iBtnRestart   (iBtnRestart),
    .iBtnPause     (iBtnPause),
    .oRestart      (oRestart),
    .oPause        (oPause),
    .oRestartPulse (oRestartPulse),
    .oTick         (oTick)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  // Reset asserted/released just after a rising edge; the next edge is cycle 1.
  task automatic applyReset(input logic r, input logic p);
    iRst_n      = 1'b0;
    iBtnRestart = r;
    iBtnPause   = p;
    @(posedge iClk); #1;
    @(posedge iClk); #1;
    iRst_n = 1'b1;
  endtask

  task automatic test_reset;
    iRst_n = 1'b0; iBtnRestart = 1'b0; iBtnPause = 1'b0;
    @(posedge iClk); #1;
    @(posedge iClk); #1;
    checks++;
    if (obs !== 4'b0000) begin
      errors++;
      $display("FAIL reset_hold got=%b want=0000", obs);
    end
    iRst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      expQ.push_back(4'b0000);
      @(posedge iClk); #1;
      expV = expQ.pop_front();
      checks++;
      if (obs !== expV) begin
        errors++;
        $display("FAIL reset_partial k=%0d got=%b want=%b", k, obs, expV);
      end
    end
    applyReset(1'b0, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      expQ.push_back({k >= 7, 1'b0, k == 7, k == 5});
      @(posedge iClk); #1;
      expV = expQ.pop_front();
      checks++;
      if (obs !== expV) begin
        errors++;
        $display("FAIL reset_redebounce k=%0d got=%b want=%b", k, obs, expV);
      end
    end
  endtask

  task automatic test_pause;
    applyReset(1'b1, 1'b1);
    for (int k = 1; k <= 25; k++) begin
      iBtnPause = (k <= 10) ? 1'b0 : 1'b1;
      expQ.push_back({1'b0, k >= 7, 1'b0, k == 5});
      @(posedge iClk); #1;
      expV = expQ.pop_front();
      checks++;
      if (obs !== expV) begin
        errors++;
        $display("FAIL pause k=%0d got=%b want=%b", k, obs, expV);
      end
    end
  endtask

  task automatic test_glitch;
    for (int k = 26; k <= 44; k++) begin
      iBtnPause = (k == 26 || k == 28 || (k >= 32 && k <= 34)) ? 1'b0 : 1'b1;
      expQ.push_back(4'b0100);
      @(posedge iClk); #1;
      expV = expQ.pop_front();
      checks++;
      if (obs !== expV) begin
        errors++;
        $display("FAIL glitch k=%0d got=%b want=%b", k, obs, expV);
      end
    end
  endtask

  task automatic test_pause_exact;
    for (int k = 45; k <= 62; k++) begin
      iBtnPause = (k <= 48) ? 1'b0 : 1'b1;
      expQ.push_back({1'b0, k <= 50, 1'b0, (k > 51) && ((k - 51) % 5 == 0)});
      @(posedge iClk); #1;
      expV = expQ.pop_front();
      checks++;
      if (obs !== expV) begin
        errors++;
        $display("FAIL pause_exact k=%0d got=%b want=%b", k, obs, expV);
      end
    end
  endtask

  task automatic test_restart;
    applyReset(1'b1, 1'b1);
    for (int k = 1; k <= 42; k++) begin
      iBtnPause   = (k <= 7 || (k >= 22 && k <= 27)) ? 1'b0 : 1'b1;
      iBtnRestart = (k >= 15 && k <= 24) ? 1'b0 : 1'b1;
      expQ.push_back({(k >= 21 && k <= 30), (k >= 7 && k <= 20), k == 21,
                      (k == 5 || k == 36 || k == 41)});
      @(posedge iClk); #1;
      expV = expQ.pop_front();
      checks++;
      if (obs !== expV) begin
        errors++;
        $display("FAIL restart k=%0d got=%b want=%b", k, obs, expV);
      end
    end
  endtask

  task automatic test_simultaneous;
    applyReset(1'b1, 1'b1);
    for (int k = 1; k <= 30; k++) begin
      iBtnPause   = (k >= 3 && k <= 12) ? 1'b0 : 1'b1;
      iBtnRestart = (k >= 3 && k <= 12) ? 1'b0 : 1'b1;
      expQ.push_back({(k >= 9 && k <= 18), 1'b0, k == 9,
                      (k == 5 || k == 24 || k == 29)});
      @(posedge iClk); #1;
      expV = expQ.pop_front();
      checks++;
      if (obs !== expV) begin
        errors++;
        $display("FAIL simultaneous k=%0d got=%b want=%b", k, obs, expV);
      end
    end
  endtask

  task automatic test_tick_reset;
    applyReset(1'b1, 1'b1);
    for (int k = 1; k <= 25; k++) begin
      expQ.push_back({3'b000, (k % 5) == 0});
      @(posedge iClk); #1;
      expV = expQ.pop_front();
      checks++;
      if (obs !== expV) begin
        errors++;
        $display("FAIL free_run k=%0d got=%b want=%b", k, obs, expV);
      end
    end
    iRst_n = 1'b0;
    #1;
    checks++;
    if (oTick !== 1'b0) begin
      errors++;
      $display("FAIL tick_async_reset got=%b want=0", oTick);
    end
    applyReset(1'b1, 1'b1);
    for (int k = 1; k <= 10; k++) begin
      expQ.push_back({3'b000, (k % 5) == 0});
      @(posedge iClk); #1;
      expV = expQ.pop_front();
      checks++;
      if (obs !== expV) begin
        errors++;
        $display("FAIL tick_restart k=%0d got=%b want=%b", k, obs, expV);
      end
    end
  endtask

  initial begin
    iRst_n      = 1'b0;
    iBtnRestart = 1'b0;
    iBtnPause   = 1'b0;
    test_reset();
    test_pause();
    test_glitch();
    test_pause_exact();
    test_restart();
    test_simultaneous();
    test_tick_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
